// File: rtl/pontuacao_jogo.sv
// Scoring datapath for the game: per-round error count, round score, saturating total
// and a sequential double-dabble engine that turns the total into four BCD digits.
module pontuacao_jogo #(
   parameter int unsigned PONTOS_BASE  = 100,
   parameter int unsigned BONUS_RODADA = 10,
   parameter int unsigned PENALIDADE   = 25,
   parameter int unsigned LIMITE_TOTAL = 9999
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        contaErro,
   input  logic        zeraErro,
   input  logic        calcular,
   input  logic        regPontos,
   input  logic        zeraPontos,
   input  logic [3:0]  rodada,
   output logic [3:0]  erros,
   output logic [7:0]  pontos_rodada,
   output logic [13:0] total,
   output logic [15:0] bcd,
   output logic        bcd_valido,
   output logic        ocupado
);

   typedef enum logic [1:0] {StOcioso, StConverte, StConclui} state_e;

   state_e      state_q, state_d;
   logic [3:0]  erros_q;
   logic [7:0]  pontos_q;
   logic [13:0] total_q;
   logic [15:0] bcd_q, bcd_d;
   logic        valido_q, valido_d;
   logic [29:0] shreg_q, shreg_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [15:0] score_full;
   logic [7:0]  score_sat;
   logic [14:0] sum_full;
   logic [13:0] sum_sat;
   logic [29:0] adj;
   logic [29:0] shifted;

   // Two's-complement wrap in 16 bits keeps negative scores detectable via the sign bit.
   always_comb begin
      score_full = 16'(PONTOS_BASE) + 16'(BONUS_RODADA) * {12'd0, rodada}
                   - 16'(PENALIDADE) * {12'd0, erros_q};
      if (score_full[15]) begin
         score_sat = 8'd0;
      end else if (score_full > 16'd255) begin
         score_sat = 8'd255;
      end else begin
         score_sat = score_full[7:0];
      end
   end

   always_comb begin
      sum_full = {1'b0, total_q} + {7'd0, pontos_q};
      if (sum_full > 15'(LIMITE_TOTAL)) begin
         sum_sat = 14'(LIMITE_TOTAL);
      end else begin
         sum_sat = sum_full[13:0];
      end
   end

   // Double-dabble step: correct every BCD nibble >= 5, then shift.
   always_comb begin
      adj = shreg_q;
      for (int i = 0; i < 4; i++) begin
         if (adj[14+4*i +: 4] >= 4'd5) begin
            adj[14+4*i +: 4] = adj[14+4*i +: 4] + 4'd3;
         end
      end
      shifted = {adj[28:0], 1'b0};
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      valido_d = 1'b0;
      if (zeraPontos) begin
         state_d = StOcioso;
         shreg_d = '0;
         cnt_d   = '0;
         bcd_d   = '0;
      end else if (regPontos) begin
         // Also restarts an in-flight conversion from the new total.
         state_d = StConverte;
         shreg_d = {16'd0, sum_sat};
         cnt_d   = '0;
      end else begin
         case (state_q)
            StConverte: begin
               shreg_d = shifted;
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd13) begin
                  state_d = StConclui;
               end
            end
            StConclui: begin
               bcd_d    = shreg_q[29:14];
               valido_d = 1'b1;
               state_d  = StOcioso;
            end
            default: state_d = StOcioso;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StOcioso;
         erros_q  <= '0;
         pontos_q <= '0;
         total_q  <= '0;
         bcd_q    <= '0;
         valido_q <= 1'b0;
         shreg_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         valido_q <= valido_d;
         if (zeraErro) begin
            erros_q <= '0;
         end else if (contaErro && (erros_q != 4'd15)) begin
            erros_q <= erros_q + 4'd1;
         end
         if (zeraPontos) begin
            pontos_q <= '0;
            total_q  <= '0;
         end else begin
            if (calcular) begin
               pontos_q <= score_sat;
            end
            if (regPontos) begin
               total_q <= sum_sat;
            end
         end
      end
   end

   assign erros         = erros_q;
   assign pontos_rodada = pontos_q;
   assign total         = total_q;
   assign bcd           = bcd_q;
   assign bcd_valido    = valido_q;
   assign ocupado       = (state_q != StOcioso);

endmodule

// File: tb/tb_pontuacao_jogo.sv
// Directed bench for pontuacao_jogo: scoring, saturation, BCD latency, restart/abort, reset.
module tb_pontuacao_jogo;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        contaErro = 1'b0, zeraErro = 1'b0, calcular = 1'b0;
   logic        regPontos = 1'b0, zeraPontos = 1'b0;
   logic [3:0]  rodada = 4'd0;
   logic [3:0]  erros;
   logic [7:0]  pontos_rodada;
   logic [13:0] total;
   logic [15:0] bcd;
   logic        bcd_valido;
   logic        ocupado;

   int n_cmp = 0;
   int n_fail = 0;
   int k;

   pontuacao_jogo dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .contaErro     (contaErro),
      .zeraErro      (zeraErro),
      .calcular      (calcular),
      .regPontos     (regPontos),
      .zeraPontos    (zeraPontos),
      .rodada        (rodada),
      .erros         (erros),
      .pontos_rodada (pontos_rodada),
      .total         (total),
      .bcd           (bcd),
      .bcd_valido    (bcd_valido),
      .ocupado       (ocupado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive strobes for exactly one rising edge; returns on the following falling edge.
   task automatic pulse(input logic ce, input logic ze, input logic ca, input logic rp,
                        input logic zp);
      contaErro = ce; zeraErro = ze; calcular = ca; regPontos = rp; zeraPontos = zp;
      @(negedge clock);
      contaErro = 0; zeraErro = 0; calcular = 0; regPontos = 0; zeraPontos = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   // Cycles until bcd_valido, counted from the last strobe edge; -1 if the bound expires.
   task automatic wait_valid(input int bound, output int cycles);
      cycles = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clock);
         if (bcd_valido) begin
            cycles = i;
            break;
         end
      end
   endtask

   initial begin
      @(negedge clock);
      check("reset_erros", 32'(erros), 32'd0);
      check("reset_pontos", 32'(pontos_rodada), 32'd0);
      check("reset_total", 32'(total), 32'd0);
      check("reset_bcd", 32'(bcd), 32'd0);
      check("reset_valido", 32'(bcd_valido), 32'd0);
      check("reset_ocupado", 32'(ocupado), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Round score 100 + 30 - 50 = 80
      rodada = 4'd3;
      pulse(1, 0, 0, 0, 0);
      pulse(1, 0, 0, 0, 0);
      check("erros_2", 32'(erros), 32'd2);
      pulse(0, 0, 1, 0, 0);
      check("pontos_80", 32'(pontos_rodada), 32'd80);
      pulse(0, 0, 0, 1, 0);
      check("total_80", 32'(total), 32'd80);
      check("ocupado_start", 32'(ocupado), 32'd1);
      idle(7);
      check("bcd_hold", 32'(bcd), 32'd0);
      check("ocupado_mid", 32'(ocupado), 32'd1);
      wait_valid(30, k);
      check("latency_80", 32'(k + 7), 32'd15);
      check("bcd_0080", 32'(bcd), 32'h0080);
      check("ocupado_done", 32'(ocupado), 32'd0);
      @(negedge clock);
      check("valido_1cyc", 32'(bcd_valido), 32'd0);

      // 100 + 150 = 250, total 330
      rodada = 4'd15;
      pulse(0, 1, 0, 0, 0);
      pulse(0, 0, 1, 0, 0);
      check("pontos_250", 32'(pontos_rodada), 32'd250);
      pulse(0, 0, 0, 1, 0);
      check("total_330", 32'(total), 32'd330);
      wait_valid(30, k);
      check("latency_330", 32'(k), 32'd15);
      check("bcd_0330", 32'(bcd), 32'h0330);

      // Penalty clamp and error saturation
      rodada = 4'd3;
      pulse(0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) pulse(1, 0, 0, 0, 0);
      check("erros_6", 32'(erros), 32'd6);
      pulse(0, 0, 1, 0, 0);
      check("pontos_clamp0", 32'(pontos_rodada), 32'd0);
      for (int i = 0; i < 20; i++) pulse(1, 0, 0, 0, 0);
      check("erros_sat15", 32'(erros), 32'd15);
      pulse(0, 0, 1, 0, 0);
      check("pontos_clamp0_15", 32'(pontos_rodada), 32'd0);
      pulse(1, 1, 0, 0, 0);
      check("zera_priority", 32'(erros), 32'd0);

      // Total saturation: 39*250 + 240 = 9990, +80 -> 9999
      pulse(0, 0, 0, 0, 1);
      check("zp_total", 32'(total), 32'd0);
      check("zp_bcd", 32'(bcd), 32'd0);
      rodada = 4'd15;
      pulse(0, 0, 1, 0, 0);
      for (int i = 0; i < 39; i++) pulse(0, 0, 0, 1, 0);
      check("total_9750", 32'(total), 32'd9750);
      rodada = 4'd14;
      pulse(0, 0, 1, 0, 0);
      check("pontos_240", 32'(pontos_rodada), 32'd240);
      pulse(0, 0, 0, 1, 0);
      check("total_9990", 32'(total), 32'd9990);
      rodada = 4'd3;
      pulse(1, 0, 0, 0, 0);
      pulse(1, 0, 0, 0, 0);
      pulse(0, 0, 1, 0, 0);
      pulse(0, 0, 0, 1, 0);
      check("total_sat", 32'(total), 32'd9999);
      wait_valid(30, k);
      check("latency_9999", 32'(k), 32'd15);
      check("bcd_9999", 32'(bcd), 32'h9999);

      // Restart: regPontos at T and T+5, single pulse at T+20
      pulse(0, 0, 0, 0, 1);
      pulse(0, 0, 1, 0, 0);
      check("pontos_80_b", 32'(pontos_rodada), 32'd80);
      pulse(0, 0, 0, 1, 0);
      wait_valid(4, k);
      check("no_early_valid", 32'(k), 32'hFFFF_FFFF);
      pulse(0, 0, 0, 1, 0);
      check("total_160", 32'(total), 32'd160);
      wait_valid(30, k);
      check("latency_restart", 32'(k), 32'd15);
      check("bcd_0160", 32'(bcd), 32'h0160);

      // Abort with zeraPontos mid-conversion
      pulse(0, 0, 0, 1, 0);
      idle(3);
      pulse(0, 0, 0, 0, 1);
      check("abort_total", 32'(total), 32'd0);
      check("abort_bcd", 32'(bcd), 32'd0);
      check("abort_ocupado", 32'(ocupado), 32'd0);
      wait_valid(25, k);
      check("abort_no_pulse", 32'(k), 32'hFFFF_FFFF);

      // Asynchronous reset mid-conversion with total 330
      rodada = 4'd15;
      pulse(0, 1, 0, 0, 0);
      pulse(0, 0, 1, 0, 0);
      pulse(0, 0, 0, 1, 0);
      rodada = 4'd3;
      pulse(1, 0, 0, 0, 0);
      pulse(1, 0, 0, 0, 0);
      pulse(0, 0, 1, 0, 0);
      pulse(0, 0, 0, 1, 0);
      check("pre_rst_total", 32'(total), 32'd330);
      idle(4);
      #2 reset_n = 1'b0;
      #1;
      check("rst_total", 32'(total), 32'd0);
      check("rst_erros", 32'(erros), 32'd0);
      check("rst_pontos", 32'(pontos_rodada), 32'd0);
      check("rst_bcd", 32'(bcd), 32'd0);
      check("rst_ocupado", 32'(ocupado), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      pulse(0, 0, 0, 1, 0);
      check("post_rst_ocupado", 32'(ocupado), 32'd1);
      wait_valid(30, k);
      check("latency_zero", 32'(k), 32'd15);
      check("bcd_0000", 32'(bcd), 32'h0000);
      check("post_rst_total", 32'(total), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pontuacao_jogo.md
Name: pontuacao_jogo

Overview:
Scoring datapath driven by the game control unit's strobes (contaErro, zeraErro, calcular, regPontos, zeraPontos).
- Counts errors per round.
- Computes the round score when calcular pulses.
- Accumulates the total score when regPontos pulses.
- Converts the total to BCD with a sequential double-dabble engine. The BCD value feeds the score display mux.

Parameters:
PONTOS_BASE, 100, base points per round
BONUS_RODADA, 10, extra points per round index
PENALIDADE, 25, points subtracted per error
LIMITE_TOTAL, 9999, saturation ceiling of the accumulated total (fits 14 bits)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
contaErro  in  1  increment error counter (1-cycle strobe)
zeraErro  in  1  clear error counter
calcular  in  1  compute round score
regPontos  in  1  add round score to total, start BCD conversion
zeraPontos  in  1  clear round score, total and BCD; abort conversion
rodada  in  4  current round index, 0..15
erros  out  4  errors in current round
pontos_rodada  out  8  registered round score
total  out  14  accumulated score
bcd  out  16  four BCD digits of total, [15:12] = thousands
bcd_valido  out  1  1-cycle pulse when bcd updates after a conversion
ocupado  out  1  conversion in progress

Behaviour:
- Reset (reset_n=0, asynchronous):
  - erros, pontos_rodada, total, bcd = 0.
  - bcd_valido = 0, ocupado = 0, FSM = OCIOSO.
- Error counter:
  - zeraErro → 0. zeraErro has priority over contaErro in the same cycle.
  - contaErro → +1, saturating at 15.
- Round score:
  - On calcular: pontos_rodada <= max(0, PONTOS_BASE + BONUS_RODADA*rodada − PENALIDADE*erros).
  - Compute at ≥10-bit signed width, then clamp to 0..255.
  - Uses the erros value present in that cycle; the result is visible 1 cycle later.
- Total:
  - On regPontos: total <= min(LIMITE_TOTAL, total + pontos_rodada).
  - Uses the registered pontos_rodada. If calcular and regPontos coincide, regPontos uses the old pontos_rodada. The control unit's calcular→regPontos spacing of 1 cycle is therefore correct.
- zeraPontos:
  - Clears pontos_rodada, total and bcd. Forces FSM to OCIOSO, ocupado = 0, no bcd_valido pulse.
  - Wins over regPontos and calcular in the same cycle.
  - May be held high for many cycles (the control unit holds it across several states).
- BCD FSM, states OCIOSO / CONVERTE / CONCLUI:
  - OCIOSO: regPontos at edge T loads the new total sum into a 30-bit shift register ({16'b0, sum}), sets bit counter = 0 and goes to CONVERTE.
  - CONVERTE: each edge adds 3 to every BCD nibble ≥5, then shifts left 1. After 14 shifts (edges T+1..T+14) go to CONCLUI.
  - CONCLUI (edge T+15): bcd <= upper 16 bits; bcd_valido = 1 for that one cycle; return to OCIOSO.
  - ocupado = 1 whenever state ≠ OCIOSO. Latency from regPontos to bcd_valido is 15 cycles.
  - bcd holds its previous value throughout a conversion.
- regPontos while ocupado: total updates normally. The conversion restarts from the new total and the counter is reset. There is no bcd_valido pulse for the aborted conversion.
- Reset mid-conversion: immediate return to reset values.

Test Plan:
1. Round score: rodada=3, 2 contaErro pulses, calcular → erros=2, pontos_rodada=80 next cycle; regPontos → total=80.
2. Penalty clamp: rodada=3, 6 errors, calcular → pontos_rodada=0. 20 contaErro pulses → erros saturates at 15. zeraErro+contaErro same cycle → erros=0.
3. BCD: total 0 → regPontos with pontos_rodada=80 → ocupado high for 15 cycles, bcd_valido pulse at T+15, bcd=0x0080. Then pontos_rodada=250 → total=330, bcd=0x0330.
4. Saturation: drive total to 9990 via repeated rounds, add 80 → total=9999, bcd=0x9999.
5. Restart/abort: regPontos at T and again at T+5 → single bcd_valido at T+20 with the final total. zeraPontos during conversion → total=0, bcd=0, ocupado=0, no pulse.
6. Reset: assert reset_n=0 mid-conversion with total=330 → all outputs 0 immediately. After release, regPontos with pontos_rodada=0 → bcd_valido pulse, bcd=0x0000.
